// File: rtl/test_pkg.sv
// Shared constants for the 4-lane dot-product datapath.
package test_pkg;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 3;
endpackage

// File: rtl/test_mult_lane.sv
// One registered multiplier lane. It outputs the low WIDTH bits of the product,
// plus a flag that is set when any of the upper product bits is set.
module dot4_mult_lane
    import test_pkg::*;
#(
    parameter int LANE_W = test_pkg::WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANE_W-1:0] x_i,
    input  logic [LANE_W-1:0] y_i,
    output logic [LANE_W-1:0] prod_o,
    output logic              ovf_o
);
    logic [2*LANE_W-1:0] full_prod;
    logic [LANE_W-1:0]   prod_q;
    logic                ovf_q;

    assign full_prod = {{LANE_W{1'b0}}, x_i} * {{LANE_W{1'b0}}, y_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= full_prod[LANE_W-1:0];
            ovf_q  <= |full_prod[2*LANE_W-1:LANE_W];
        end
    end

    assign prod_o = prod_q;
    assign ovf_o  = ovf_q;
endmodule

// File: rtl/test.sv
// Pipelined unsigned dot product of two 4-lane vectors. The datapath is
// multiply -> pair add -> final add, and the result is taken modulo 2^WIDTH.
module test
    import test_pkg::*;
#(
    parameter int WIDTH = test_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] c2,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] sum,
    output logic             valid,
    output logic             ovf
);
    // valid has no ready partner. It rises on the LATENCY-th edge after reset
    // is released. From then on, every cycle carries one result.
    logic [WIDTH-1:0] prod_a, prod_b, prod_c, prod_d;
    logic             ovf_a, ovf_b, ovf_c, ovf_d;

    dot4_mult_lane #(.LANE_W(WIDTH)) u_lane_a (.clk(clk), .rst_n(rst_n), .x_i(a1), .y_i(a2), .prod_o(prod_a), .ovf_o(ovf_a));
    dot4_mult_lane #(.LANE_W(WIDTH)) u_lane_b (.clk(clk), .rst_n(rst_n), .x_i(b1), .y_i(b2), .prod_o(prod_b), .ovf_o(ovf_b));
    dot4_mult_lane #(.LANE_W(WIDTH)) u_lane_c (.clk(clk), .rst_n(rst_n), .x_i(c1), .y_i(c2), .prod_o(prod_c), .ovf_o(ovf_c));
    dot4_mult_lane #(.LANE_W(WIDTH)) u_lane_d (.clk(clk), .rst_n(rst_n), .x_i(d1), .y_i(d2), .prod_o(prod_d), .ovf_o(ovf_d));

    logic [WIDTH:0]     p0_d, p0_q, p1_d, p1_q;
    logic               ovf2_d, ovf2_q;
    logic [WIDTH+1:0]   total;
    logic [WIDTH-1:0]   sum_d, sum_q;
    logic               ovf3_d, ovf3_q;
    logic [LATENCY-1:0] vld_d, vld_q;

    always_comb begin
        p0_d   = {1'b0, prod_a} + {1'b0, prod_b};
        p1_d   = {1'b0, prod_c} + {1'b0, prod_d};
        ovf2_d = ovf_a | ovf_b | ovf_c | ovf_d;
        total  = {1'b0, p0_q} + {1'b0, p1_q};
        sum_d  = total[WIDTH-1:0];
        // The partial-sum carries sit in bit WIDTH of p0_q and p1_q.
        // Bits above WIDTH of total catch the final carry.
        ovf3_d = ovf2_q | p0_q[WIDTH] | p1_q[WIDTH] | (|total[WIDTH+1:WIDTH]);
        vld_d  = {vld_q[LATENCY-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q   <= '0;
            p1_q   <= '0;
            ovf2_q <= 1'b0;
            sum_q  <= '0;
            ovf3_q <= 1'b0;
            vld_q  <= '0;
        end else begin
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            ovf2_q <= ovf2_d;
            sum_q  <= sum_d;
            ovf3_q <= ovf3_d;
            vld_q  <= vld_d;
        end
    end

    assign sum   = sum_q;
    assign ovf   = ovf3_q;
    assign valid = vld_q[LATENCY-1];
endmodule

// File: tb/tb_test.sv
// Directed-vector bench for the dot-product pipeline. The driver pushes the expected {ovf,sum} for each vector.
// A monitor pops and checks one entry every valid cycle.
module tb_test;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a1, b1, c1, d1, a2, b2, c2, d2;
    logic [W-1:0] sum;
    logic         valid, ovf;

    logic [W:0]   exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           edges_since_rst = 0;

    test #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a1(a1), .b1(b1), .c1(c1), .d1(d1),
        .a2(a2), .b2(b2), .c2(c2), .d2(d2),
        .sum(sum), .valid(valid), .ovf(ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    // driver: inputs change 2 time units after a posedge, and each vector is sampled on the next posedge
    task automatic apply(input logic [W-1:0] va1, vb1, vc1, vd1, va2, vb2, vc2, vd2,
                         input logic [W-1:0] exp_sum, input logic exp_ovf);
        a1 = va1; b1 = vb1; c1 = vc1; d1 = vd1;
        a2 = va2; b2 = vb2; c2 = vc2; d2 = vd2;
        exp_q.push_back({exp_ovf, exp_sum});
        @(posedge clk);
        #2;
        edges_since_rst++;
        if (edges_since_rst <= 3)
            check($sformatf("valid_edge%0d", edges_since_rst), {{W{1'b0}}, valid},
                  {{W{1'b0}}, (edges_since_rst == 3)});
    endtask

    task automatic vec_twos();   apply(2, 2, 2, 2, 2, 2, 2, 2, 32'd16, 1'b0); endtask
    task automatic vec_seq();    apply(3, 5, 7, 9, 4, 6, 8, 10, 32'd188, 1'b0); endtask
    task automatic vec_zero();   apply(0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0); endtask
    task automatic vec_wrap();   apply(32'hFFFF_FFFF, 0, 0, 0, 2, 0, 0, 0, 32'hFFFF_FFFE, 1'b1); endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && valid && exp_q.size() > 0) begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("result", {ovf, sum}, e);
        end
    end

    initial begin
        rst_n = 1'b0;
        a1 = '0; b1 = '0; c1 = '0; d1 = '0;
        a2 = '0; b2 = '0; c2 = '0; d2 = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_sum",   {1'b0, sum},           '0);
        check("rst_valid", {{W{1'b0}}, valid},    '0);
        check("rst_ovf",   {{W{1'b0}}, ovf},      '0);
        rst_n = 1'b1;
        edges_since_rst = 0;

        vec_twos();
        vec_seq();
        vec_zero();
        vec_wrap();
        // every lane 0x8000_0000 * 1: both partial sums carry
        apply(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1, 1, 1, 1, 32'd0, 1'b1);
        // only the final add carries
        apply(32'h8000_0000, 0, 32'h8000_0000, 0, 1, 0, 1, 0, 32'd0, 1'b1);
        // 2^16 * 2^16 has only bit 32 set, so the lane value is 0 and ovf is set
        apply(32'h0001_0000, 0, 0, 0, 32'h0001_0000, 0, 0, 0, 32'd0, 1'b1);
        // largest value with no loss
        apply(32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 1'b0);
        vec_seq();
        vec_twos();

        // mid-stream asynchronous reset
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_sum",   {1'b0, sum},        '0);
        check("midrst_valid", {{W{1'b0}}, valid}, '0);
        check("midrst_ovf",   {{W{1'b0}}, ovf},   '0);
        @(posedge clk);
        #2;
        check("midrst_hold", {ovf, sum}, '0);
        rst_n = 1'b1;
        edges_since_rst = 0;

        vec_seq();
        vec_wrap();
        vec_twos();
        vec_zero();

        // drain: the last vector is checked after the third edge that follows it
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
